miner_nonce_scheduler: RTL and testbench

Sequences one miner core through an inclusive range of nonces for a fixed 608-bit block header.
- Per attempt: presents a nonce, pulses the core's hash enable, waits for the core's finished flag, then samples correct.
- Stops on the first winning nonce or at the end of the range, and reports the golden nonce and hash.
- Sits between the host/config interface and the miner core.

---
 rtl/miner_nonce_scheduler.sv | 148 ++++++++++++++
 tb/tb_miner_nonce_scheduler.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/miner_nonce_scheduler.sv
// Nonce scheduler: walks one miner core through an inclusive nonce range.
// Optional per-attempt watchdog enabled by defining MINER_SCHED_TIMEOUT_EN.
module miner_nonce_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       start_nonce,
  input  logic [31:0]       end_nonce,
  input  logic              core_finished,
  input  logic              core_correct,
  input  logic [255:0]      core_hashed,
  output logic              hash_enable,
  output logic [31:0]       nonce,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [31:0]       golden_nonce,
  output logic [255:0]      golden_hash,
  output logic [CNT_W-1:0]  attempts,
  output logic              timed_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [31:0]  end_q;
  logic         seen_low;
  logic         corr_q;
  logic [255:0] hash_q;
  logic         fin_edge;
  logic         last;
  logic         tmo;
  logic         in_run;
  logic         kill;

  assign in_run   = (state == S_LAUNCH) || (state == S_WAIT) ||
                    (state == S_CHECK);
  assign kill     = abort && in_run;
  assign fin_edge = (state == S_WAIT) && seen_low && core_finished;
  assign last     = (nonce == end_q);

`ifdef MINER_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt;

  assign tmo = (state == S_WAIT) && !fin_edge &&
               (wcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= '0;
      timed_out <= 1'b0;
    end else begin
      if (state == S_IDLE && start) timed_out <= 1'b0;
      if (state == S_LAUNCH) wcnt <= '0;
      if (state == S_WAIT && !abort) begin
        wcnt <= wcnt + TW'(1);
        if (tmo) timed_out <= 1'b1;
      end
    end
  end
`else
  assign tmo       = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (fin_edge) state_nx = S_CHECK;
        else if (tmo) state_nx = S_DONE;
      end
      S_CHECK:  state_nx = (corr_q || last) ? S_DONE : S_LAUNCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    // abort outranks everything, including a winner in CHECK
    if (kill) state_nx = S_IDLE;
  end

  always_comb begin
    hash_enable = (state == S_LAUNCH);
    busy        = in_run;
    done        = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nonce        <= '0;
      end_q        <= '0;
      seen_low     <= 1'b0;
      corr_q       <= 1'b0;
      hash_q       <= '0;
      found        <= 1'b0;
      golden_nonce <= '0;
      golden_hash  <= '0;
      attempts     <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        nonce        <= start_nonce;
        end_q        <= end_nonce;
        attempts     <= '0;
        found        <= 1'b0;
        golden_nonce <= '0;
        golden_hash  <= '0;
      end
      if (state == S_LAUNCH) seen_low <= 1'b0;
      // a finished flag left high by the last attempt must drop first
      if (state == S_WAIT && !abort) begin
        if (!core_finished) seen_low <= 1'b1;
        if (fin_edge) begin
          corr_q <= core_correct;
          hash_q <= core_hashed;
        end
      end
      if (state == S_CHECK && !abort) begin
        if (!(&attempts)) attempts <= attempts + CNT_W'(1);
        if (corr_q) begin
          found        <= 1'b1;
          golden_nonce <= nonce;
          golden_hash  <= hash_q;
        end else if (!last) begin
          nonce <= nonce + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// Directed bench for miner_nonce_scheduler with a small miner core model.
// Timeout scenario active when MINER_SCHED_TIMEOUT_EN is defined.
module tb_miner_nonce_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [31:0]  start_nonce;
  logic [31:0]  end_nonce;
  logic         core_finished;
  logic         core_correct;
  logic [255:0] core_hashed;
  logic         hash_enable;
  logic [31:0]  nonce;
  logic         busy;
  logic         done;
  logic         found;
  logic [31:0]  golden_nonce;
  logic [255:0] golden_hash;
  logic [31:0]  attempts;
  logic         timed_out;

  always #5 clk = ~clk;

  miner_nonce_scheduler #(
    .TIMEOUT_CYCLES(20),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .start_nonce(start_nonce),
    .end_nonce(end_nonce),
    .core_finished(core_finished),
    .core_correct(core_correct),
    .core_hashed(core_hashed),
    .hash_enable(hash_enable),
    .nonce(nonce),
    .busy(busy),
    .done(done),
    .found(found),
    .golden_nonce(golden_nonce),
    .golden_hash(golden_hash),
    .attempts(attempts),
    .timed_out(timed_out)
  );

  int checks = 0;
  int failures = 0;

  // core model configuration
  int          lat = 3;
  int          hold_cfg = 0;
  bit          never = 1'b0;
  bit          win_en = 1'b0;
  logic [31:0] win_nonce = 32'h0;
  int          cnt;
  int          hold;

  function automatic logic [255:0] hash_of(input logic [31:0] n);
    return {8{n ^ 32'h5A5AC3C3}};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      core_finished <= 1'b0;
      core_correct  <= 1'b0;
      core_hashed   <= '0;
      cnt  <= 0;
      hold <= 0;
    end else if (hash_enable) begin
      hold <= hold_cfg;
      cnt  <= never ? 0 : lat;
      if (hold_cfg == 0) begin
        core_finished <= 1'b0;
        core_correct  <= 1'b0;
      end
    end else if (hold > 0) begin
      hold <= hold - 1;
      if (hold == 1) core_finished <= 1'b0;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        core_finished <= 1'b1;
        core_correct  <= win_en && (nonce == win_nonce);
        core_hashed   <= hash_of(nonce);
      end
    end
  end

  int          he_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] nlog[$];

  always @(negedge clk) begin
    if (hash_enable === 1'b1) begin
      he_cnt++;
      nlog.push_back(nonce);
    end
    if (done === 1'b1) done_cnt++;
  end

  int he_base;
  int done_base;
  int log_base;

  task automatic do_start(input logic [31:0] s, input logic [31:0] e);
    @(negedge clk);
    start_nonce = s;
    end_nonce   = e;
    start       = 1'b1;
    he_base     = he_cnt;
    done_base   = done_cnt;
    log_base    = nlog.size();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < maxc && !ok) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL done_wait: no done within %0d cycles", maxc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    start_nonce = '0;
    end_nonce = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({hash_enable, busy, done, found, timed_out} !== 5'b0) begin
      failures++;
      $display("FAIL rst_flags: got %b exp 00000",
               {hash_enable, busy, done, found, timed_out});
    end
    checks++;
    if (nonce !== 32'h0 || attempts !== 32'h0) begin
      failures++;
      $display("FAIL rst_regs: nonce=%h attempts=%0d exp 0", nonce, attempts);
    end
    rst = 1'b0;
    never = 1'b1;
    do_start(32'h55, 32'h60);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midwait_busy: got %b exp 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({hash_enable, busy, done, found, timed_out} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_flags: got %b exp 00000",
               {hash_enable, busy, done, found, timed_out});
    end
    checks++;
    if (nonce !== 0 || golden_nonce !== 0 || golden_hash !== 0 ||
        attempts !== 0) begin
      failures++;
      $display("FAIL midrst_regs: nonce=%h gn=%h att=%0d exp 0",
               nonce, golden_nonce, attempts);
    end
    he_base = he_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if (he_cnt !== he_base || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet: pulses=%0d busy=%b exp 0 0",
               he_cnt - he_base, busy);
    end
    never = 1'b0;
  endtask

  task automatic test_winner();
    int n;
    bit ok;
    win_en = 1'b1;
    win_nonce = 32'h14;
    lat = 3;
    hold_cfg = 0;
    do_start(32'h10, 32'h1F);
    wait_done(400, n, ok);
    checks++;
    if (found !== 1'b1 || golden_nonce !== 32'h14) begin
      failures++;
      $display("FAIL win_golden: found=%b gn=%h exp 1 14", found, golden_nonce);
    end
    checks++;
    if (golden_hash !== hash_of(32'h14)) begin
      failures++;
      $display("FAIL win_hash: got %h exp %h", golden_hash, hash_of(32'h14));
    end
    checks++;
    if (attempts !== 32'd5 || he_cnt - he_base !== 5) begin
      failures++;
      $display("FAIL win_count: att=%0d pulses=%0d exp 5 5",
               attempts, he_cnt - he_base);
    end
    checks++;
    if (n !== 30 || busy !== 1'b0) begin
      failures++;
      $display("FAIL win_latency: cycles=%0d busy=%b exp 30 0", n, busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (nlog.size() <= log_base + i ||
          nlog[log_base + i] !== 32'h10 + 32'(i)) begin
        failures++;
        $display("FAIL win_seq%0d: got %h exp %h", i,
                 (nlog.size() > log_base + i) ? nlog[log_base + i] : 32'hx,
                 32'h10 + 32'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || found !== 1'b1 || done_cnt - done_base !== 1) begin
      failures++;
      $display("FAIL win_hold: done=%b found=%b pulses=%0d exp 0 1 1",
               done, found, done_cnt - done_base);
    end
  endtask

  task automatic test_stale();
    int n;
    bit ok;
    hold_cfg = 3;
    lat = 2;
    do_start(32'h7, 32'h7);
    wait_done(100, n, ok);
    checks++;
    if (found !== 1'b0 || attempts !== 32'd1) begin
      failures++;
      $display("FAIL stale_result: found=%b att=%0d exp 0 1", found, attempts);
    end
    checks++;
    if (golden_nonce !== 32'h0 || golden_hash !== 256'h0) begin
      failures++;
      $display("FAIL stale_clear: gn=%h exp 0", golden_nonce);
    end
    checks++;
    if (he_cnt - he_base !== 1 || nlog[log_base] !== 32'h7) begin
      failures++;
      $display("FAIL stale_pulse: pulses=%0d nonce=%h exp 1 7",
               he_cnt - he_base, nlog[log_base]);
    end
    checks++;
    if (n !== 8) begin
      failures++;
      $display("FAIL stale_latency: got %0d exp 8", n);
    end
    hold_cfg = 0;
  endtask

  task automatic test_wrap();
    int n;
    bit ok;
    logic [31:0] exp_seq[4];
    exp_seq = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    win_en = 1'b0;
    lat = 1;
    do_start(32'hFFFFFFFE, 32'h1);
    wait_done(200, n, ok);
    checks++;
    if (found !== 1'b0 || attempts !== 32'd4 || he_cnt - he_base !== 4) begin
      failures++;
      $display("FAIL wrap_result: found=%b att=%0d pulses=%0d exp 0 4 4",
               found, attempts, he_cnt - he_base);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nlog.size() <= log_base + i || nlog[log_base + i] !== exp_seq[i]) begin
        failures++;
        $display("FAIL wrap_seq%0d: got %h exp %h", i,
                 (nlog.size() > log_base + i) ? nlog[log_base + i] : 32'hx,
                 exp_seq[i]);
      end
    end
  endtask

  task automatic test_abort_race();
    int n;
    bit ok;
    win_en = 1'b1;
    win_nonce = 32'h20;
    lat = 3;
    do_start(32'h20, 32'h30);
    @(negedge clk);
    start = 1'b1;
    start_nonce = 32'h99;
    end_nonce = 32'h99;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (core_finished !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || found !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_race: busy=%b found=%b done=%b exp 0 0 0",
               busy, found, done);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt !== done_base || he_cnt - he_base !== 1 ||
        nlog[log_base] !== 32'h20 || golden_nonce !== 32'h0) begin
      failures++;
      $display("FAIL abort_quiet: dones=%0d pulses=%0d n0=%h gn=%h exp 0 1 20 0",
               done_cnt - done_base, he_cnt - he_base, nlog[log_base],
               golden_nonce);
    end
    // start and abort together in IDLE: start wins
    win_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    start_nonce = 32'h40;
    end_nonce = 32'h40;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (hash_enable !== 1'b1 || busy !== 1'b1 || nonce !== 32'h40) begin
      failures++;
      $display("FAIL start_wins: he=%b busy=%b nonce=%h exp 1 1 40",
               hash_enable, busy, nonce);
    end
    wait_done(100, n, ok);
    checks++;
    if (attempts !== 32'd1 || found !== 1'b0) begin
      failures++;
      $display("FAIL start_wins_end: att=%0d found=%b exp 1 0", attempts, found);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    never = 1'b1;
    do_start(32'h100, 32'h200);
`ifdef MINER_SCHED_TIMEOUT_EN
    wait_done(100, n, ok);
    checks++;
    if (n !== 21 || timed_out !== 1'b1 || found !== 1'b0) begin
      failures++;
      $display("FAIL timeout: cycles=%0d to=%b found=%b exp 21 1 0",
               n, timed_out, found);
    end
    never = 1'b0;
    win_en = 1'b1;
    win_nonce = 32'h300;
    do_start(32'h300, 32'h300);
    wait_done(100, n, ok);
    checks++;
    if (timed_out !== 1'b0 || found !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear: to=%b found=%b exp 0 1", timed_out, found);
    end
`else
    repeat (60) @(negedge clk);
    checks++;
    if (done_cnt !== done_base || busy !== 1'b1 || timed_out !== 1'b0) begin
      failures++;
      $display("FAIL wait_forever: dones=%0d busy=%b to=%b exp 0 1 0",
               done_cnt - done_base, busy, timed_out);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL wait_abort: busy=%b done=%b exp 0 0", busy, done);
    end
    n = 0;
    ok = 1'b0;
    never = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_winner();
    test_stale();
    test_wrap();
    test_abort_race();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
